mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4, SHALL set the number of consecutive denied cycles after which the instruction port gets priority (legal 1..15).
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_req  input  1  instruction-port read request; held with i_address stable until granted.
REQ-005 i_address  input  16  instruction-port byte address.
REQ-006 i_gnt  output  1  instruction-port grant; combinational, same cycle as the memory access.
REQ-007 i_rvalid  output  1  instruction read data valid; one-cycle pulse.
REQ-008 i_read_data  output  32  registered instruction read data.
REQ-009 i_err  output  1  misaligned-access flag; qualified by i_rvalid.
REQ-010 d_req  input  1  data-port request; held with d_wEn, d_address and d_write_data stable until granted.
REQ-011 d_wEn  input  1  data-port write enable (1 write, 0 read).
REQ-012 d_address  input  16  data-port byte address.
REQ-013 d_write_data  input  32  data-port write data.
REQ-014 d_gnt, d_rvalid, d_read_data[31:0], d_err  output  data-port equivalents of REQ-006..009.
REQ-015 mem_wEn  output  1  memory write enable.
REQ-016 mem_address  output  16  memory byte address.
REQ-017 mem_write_data  output  32  memory write data.
REQ-018 mem_read_data  input  32  combinational memory read data for mem_address.

Function
REQ-019 At most one of i_gnt/d_gnt SHALL be high per cycle; a grant SHALL only go to a requesting port.
REQ-020 State machine: PRIO_D (default) and PRIO_I.
- PRIO_D: d_req wins.
- PRIO_I: i_req wins.
REQ-021 Wait counter (4 bits) SHALL:
- increment each cycle i_req=1 and i_gnt=0;
- clear whenever i_gnt=1 or i_req=0.
REQ-022 Transition PRIO_D->PRIO_I SHALL occur on the edge where the counter reaches MAX_WAIT.
- PRIO_I->PRIO_D SHALL occur on the edge following any i_gnt.
REQ-023 The granted port's address SHALL drive mem_address.
- mem_write_data SHALL follow d_write_data.
- mem_wEn = d_gnt & d_wEn & aligned.
- With no grant: mem_wEn=0, mem_address=0.
REQ-024 Aligned means address[1:0]==2'b00; a misaligned access SHALL NOT write memory.
REQ-025 On the edge after a grant, the granted port's rvalid SHALL be 1 for exactly one cycle.
- read_data SHALL hold the mem_read_data sampled at the grant (0 if misaligned).
- err SHALL be 1 if misaligned.
REQ-026 For a data write, d_rvalid SHALL still pulse as a completion acknowledge, with d_read_data = pre-write memory contents.
REQ-027 read_data and err SHALL hold their last values while rvalid=0.
REQ-028 Back-to-back grants to the same port on consecutive cycles SHALL be supported, giving a throughput of 1 access/cycle.
REQ-029 Simultaneous requests with counter < MAX_WAIT in PRIO_D SHALL grant the data port.

Reset
REQ-030 While reset=1, regardless of clock:
- state=PRIO_D, counter=0;
- all rvalid/err=0, all read_data=0;
- grants and mem_wEn=0.
REQ-031 An access granted in the cycle reset asserts SHALL produce no rvalid; the requester re-requests.

Structure
REQ-032 A shared package SHALL hold:
- the state enum (PRIO_D, PRIO_I);
- ADDR_W=16, DATA_W=32 and the default MAX_WAIT.
REQ-033 One sub-module, mem_port_resp, SHALL implement the per-port rvalid/read_data/err register and be instantiated twice.
REQ-034 The memory itself SHALL be external; mem_arbiter contains no storage array.

Verification
REQ-035 Instruction read only: i_req=1, i_address=0x0010, memory word 4=0xDEADBEEF -> i_gnt same cycle; next cycle i_rvalid=1, i_read_data=0xDEADBEEF, i_err=0.
REQ-036 Data write then read: d_wEn=1, d_address=0x0020, d_write_data=0x12345678, then d_wEn=0 same address -> second d_read_data=0x12345678.
REQ-037 Starvation: d_req and i_req held continuously, MAX_WAIT=4 -> d_gnt for 4 cycles, then i_gnt on the 5th cycle, then d_gnt resumes.
REQ-038 Misaligned write: d_wEn=1, d_address=0x0022 -> mem_wEn=0, next cycle d_rvalid=1, d_err=1, memory word 8 unchanged.
REQ-039 Reset mid-operation: reset asserted during an i_gnt cycle -> no i_rvalid; state=PRIO_D, counter=0 immediately.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and constants for the two-port (instruction/data) memory
// arbiter: arbitration state enum, bus widths, default starvation limit and
// the word-alignment helper used by both ports.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int ADDR_W           = 16;
    localparam int DATA_W           = 32;
    localparam int MAX_WAIT_DEFAULT = 4;

    // PRIO_D: data port wins a collision; PRIO_I: instruction port wins.
    typedef enum logic {
        PRIO_D = 1'b0,
        PRIO_I = 1'b1
    } arb_state_e;

    // Word accesses only: the two byte-offset bits must be zero.
    function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mem_port_resp.sv
// -----------------------------------------------------------------------------
// mem_port_resp
// Per-port response register. On the edge after a grant it raises rvalid for
// one cycle and captures the memory read data (forced to zero for a
// misaligned access) together with the misalignment flag. read_data and err
// hold their values while rvalid is low.
//
// Ports:
//   clock, reset       clock / asynchronous active-high reset
//   gnt                this port owns the memory this cycle
//   aligned            the granted address is word aligned
//   mem_read_data      combinational memory read data for the granted address
//   rvalid             one-cycle response strobe
//   read_data          captured read data
//   err                misaligned-access flag, qualified by rvalid
// -----------------------------------------------------------------------------
module mem_port_resp
    import mem_arbiter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              gnt,
    input  logic              aligned,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              rvalid,
    output logic [DATA_W-1:0] read_data,
    output logic              err
);

    logic              rvalid_d, rvalid_q;
    logic [DATA_W-1:0] read_data_d, read_data_q;
    logic              err_d, err_q;

    always_comb begin
        rvalid_d    = gnt;
        read_data_d = read_data_q;
        err_d       = err_q;
        if (gnt) begin
            read_data_d = aligned ? mem_read_data : '0;
            err_d       = ~aligned;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rvalid_q    <= 1'b0;
            read_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            rvalid_q    <= rvalid_d;
            read_data_q <= read_data_d;
            err_q       <= err_d;
        end
    end

    assign rvalid    = rvalid_q;
    assign read_data = read_data_q;
    assign err       = err_q;

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates a single external single-cycle memory between an instruction
// read port and a data read/write port. The data port normally wins; once the
// instruction port has been denied MAX_WAIT consecutive cycles, priority flips
// to the instruction port until it is served once.
//
// Ports:
//   clock, reset                       clock / asynchronous active-high reset
//   i_req, i_address                   instruction read request
//   i_gnt, i_rvalid, i_read_data, i_err instruction grant and response
//   d_req, d_wEn, d_address,
//   d_write_data                       data read/write request
//   d_gnt, d_rvalid, d_read_data, d_err data grant and response
//   mem_wEn, mem_address,
//   mem_write_data, mem_read_data      external memory interface
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_read_data,
    output logic              i_err,

    input  logic              d_req,
    input  logic              d_wEn,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_write_data,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_read_data,
    output logic              d_err,

    output logic              mem_wEn,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    arb_state_e state_d, state_q;
    logic [3:0] wait_cnt_d, wait_cnt_q;
    logic       i_aligned, d_aligned;

    assign i_aligned = is_aligned(i_address);
    assign d_aligned = is_aligned(d_address);

    // Grants are suppressed during reset so an access in flight when reset
    // asserts never reaches memory or produces a response.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (state_q == PRIO_I) begin
                i_gnt = i_req;
                d_gnt = d_req & ~i_req;
            end else begin
                d_gnt = d_req;
                i_gnt = i_req & ~d_req;
            end
        end
    end

    always_comb begin
        mem_address    = '0;
        mem_wEn        = 1'b0;
        mem_write_data = d_write_data;
        if (i_gnt) begin
            mem_address = i_address;
        end else if (d_gnt) begin
            mem_address = d_address;
            mem_wEn     = d_wEn & d_aligned;
        end
    end

    // The counter cannot normally pass MAX_WAIT because priority flips there;
    // it saturates anyway so it can never wrap back below the threshold.
    always_comb begin
        wait_cnt_d = '0;
        if (i_req && !i_gnt) begin
            wait_cnt_d = (wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1;
        end
    end

    // Flip to PRIO_I on the edge the counter reaches the limit; return to
    // PRIO_D on the edge after the instruction port is served.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PRIO_D:  if (wait_cnt_d == MAX_WAIT_C) state_d = PRIO_I;
            PRIO_I:  if (i_gnt)                    state_d = PRIO_D;
            default: state_d = PRIO_D;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= PRIO_D;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    mem_port_resp u_i_resp (
        .clock         (clock),
        .reset         (reset),
        .gnt           (i_gnt),
        .aligned       (i_aligned),
        .mem_read_data (mem_read_data),
        .rvalid        (i_rvalid),
        .read_data     (i_read_data),
        .err           (i_err)
    );

    mem_port_resp u_d_resp (
        .clock         (clock),
        .reset         (reset),
        .gnt           (d_gnt),
        .aligned       (d_aligned),
        .mem_read_data (mem_read_data),
        .rvalid        (d_rvalid),
        .read_data     (d_read_data),
        .err           (d_err)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter with MAX_WAIT=4. A behavioural
// 64-word memory sits on the memory port; unwritten words read back a fixed
// pattern (word 4 = 0xDEADBEEF, others 0xA50000nn).
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clock;
    logic        reset;
    logic        i_req;
    logic [15:0] i_address;
    logic        i_gnt, i_rvalid, i_err;
    logic [31:0] i_read_data;
    logic        d_req, d_wEn;
    logic [15:0] d_address;
    logic [31:0] d_write_data;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_read_data;
    logic        mem_wEn;
    logic [15:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.MAX_WAIT(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .i_req          (i_req),
        .i_address      (i_address),
        .i_gnt          (i_gnt),
        .i_rvalid       (i_rvalid),
        .i_read_data    (i_read_data),
        .i_err          (i_err),
        .d_req          (d_req),
        .d_wEn          (d_wEn),
        .d_address      (d_address),
        .d_write_data   (d_write_data),
        .d_gnt          (d_gnt),
        .d_rvalid       (d_rvalid),
        .d_read_data    (d_read_data),
        .d_err          (d_err),
        .mem_wEn        (mem_wEn),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural memory
    logic [31:0] mem     [0:63];
    logic        written [0:63];
    logic        tb_init;
    logic [5:0]  widx;

    assign widx = mem_address[7:2];

    function automatic logic [31:0] init_word(input logic [5:0] idx);
        return (idx == 6'd4) ? 32'hDEADBEEF : {24'hA50000, 2'b00, idx};
    endfunction

    always @(posedge clock) begin
        if (tb_init) begin
            for (int k = 0; k < 64; k++) written[k] <= 1'b0;
        end else if (mem_wEn) begin
            mem[widx]     <= mem_write_data;
            written[widx] <= 1'b1;
        end
    end

    assign mem_read_data = written[widx] ? mem[widx] : init_word(widx);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; tb_init = 1'b1;
        i_req = 1'b1; i_address = 16'h0010;
        d_req = 1'b1; d_wEn = 1'b1; d_address = 16'h0020; d_write_data = 32'hFFFF_FFFF;

        // ---- reset: requests present but nothing granted or written
        #2;
        check("rst_i_gnt",  i_gnt, 0);
        check("rst_d_gnt",  d_gnt, 0);
        check("rst_mem_wen", mem_wEn, 0);
        check("rst_mem_addr", mem_address, 0);
        tick(); tick();
        check("rst_i_rvalid", i_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_i_rdata", i_read_data, 0);
        check("rst_d_rdata", d_read_data, 0);
        check("rst_d_err", d_err, 0);
        check("rst_state", 32'(dut.state_q), 32'(PRIO_D));
        i_req = 1'b0; d_req = 1'b0; d_wEn = 1'b0;
        reset = 1'b0; tb_init = 1'b0;
        tick();

        // ---- instruction read of word 4
        i_req = 1'b1; i_address = 16'h0010;
        #1;
        check("ird_i_gnt", i_gnt, 1);
        check("ird_d_gnt", d_gnt, 0);
        check("ird_mem_addr", mem_address, 32'h0010);
        tick();
        i_req = 1'b0;
        check("ird_rvalid", i_rvalid, 1);
        check("ird_rdata", i_read_data, 32'hDEADBEEF);
        check("ird_err", i_err, 0);
        check("ird_d_rvalid", d_rvalid, 0);
        tick();
        check("ird_rvalid_pulse", i_rvalid, 0);
        check("ird_rdata_hold", i_read_data, 32'hDEADBEEF);

        // ---- data write then back-to-back read of the same word
        d_req = 1'b1; d_wEn = 1'b1; d_address = 16'h0020; d_write_data = 32'h12345678;
        #1;
        check("dwr_gnt", d_gnt, 1);
        check("dwr_mem_wen", mem_wEn, 1);
        check("dwr_mem_addr", mem_address, 32'h0020);
        check("dwr_mem_wdata", mem_write_data, 32'h12345678);
        tick();
        d_wEn = 1'b0;
        check("dwr_rvalid", d_rvalid, 1);
        check("dwr_pre_data", d_read_data, 32'hA5000008);
        #1;
        check("drd_gnt", d_gnt, 1);
        check("drd_mem_wen", mem_wEn, 0);
        tick();
        d_req = 1'b0;
        check("drd_rvalid", d_rvalid, 1);
        check("drd_rdata", d_read_data, 32'h12345678);
        check("drd_err", d_err, 0);
        tick();
        check("drd_rvalid_pulse", d_rvalid, 0);

        // ---- misaligned data write must not touch memory
        d_req = 1'b1; d_wEn = 1'b1; d_address = 16'h0022; d_write_data = 32'hCAFEF00D;
        #1;
        check("mis_gnt", d_gnt, 1);
        check("mis_mem_wen", mem_wEn, 0);
        tick();
        d_wEn = 1'b0; d_address = 16'h0020;
        check("mis_rvalid", d_rvalid, 1);
        check("mis_err", d_err, 1);
        check("mis_rdata", d_read_data, 0);
        tick();
        d_req = 1'b0;
        check("mis_word8", d_read_data, 32'h12345678);
        check("mis_err_clr", d_err, 0);

        // ---- misaligned instruction read
        i_req = 1'b1; i_address = 16'h0013;
        tick();
        i_req = 1'b0;
        check("imis_rvalid", i_rvalid, 1);
        check("imis_err", i_err, 1);
        check("imis_rdata", i_read_data, 0);
        tick();

        // ---- starvation: both ports held, data wins 4 cycles, then instruction
        d_req = 1'b1; d_wEn = 1'b0; d_address = 16'h0020;
        i_req = 1'b1; i_address = 16'h0010;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("starve_d%0d", c), d_gnt, (c != 4));
            check($sformatf("starve_i%0d", c), i_gnt, (c == 4));
            tick();
            if (c == 3) begin
                check("starve_state", 32'(dut.state_q), 32'(PRIO_I));
                check("starve_cnt", dut.wait_cnt_q, 4);
            end
            if (c == 4) begin
                check("starve_i_rvalid", i_rvalid, 1);
                check("starve_i_rdata", i_read_data, 32'hDEADBEEF);
                check("starve_d_rvalid", d_rvalid, 0);
            end
        end

        // ---- reset asserted during an instruction grant
        d_req = 1'b0; i_req = 1'b0;
        tick();
        d_req = 1'b1; i_req = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        #1;
        check("rmid_i_gnt_pre", i_gnt, 1);
        reset = 1'b1;
        #1;
        check("rmid_i_gnt", i_gnt, 0);
        check("rmid_state", 32'(dut.state_q), 32'(PRIO_D));
        check("rmid_cnt", dut.wait_cnt_q, 0);
        check("rmid_mem_addr", mem_address, 0);
        d_req = 1'b0; i_req = 1'b0;
        tick();
        check("rmid_i_rvalid_rst", i_rvalid, 0);
        reset = 1'b0;
        tick();
        check("rmid_i_rvalid", i_rvalid, 0);
        check("rmid_i_rdata", i_read_data, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
